// File: rtl/mips_fetch.sv
// Instruction-fetch stage: holds the PC, fetches one word at a time over a
// req/ack handshake, and resolves the next PC once the datapath retires it.
module mips_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_data_in,
    output logic [31:0] instr_out,
    output logic [5:0]  op_out,
    output logic [5:0]  func_out,
    output logic        instr_valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    input  logic        exec_done_in,
    input  logic        branch_in,
    input  logic        bne_in,
    input  logic        jump_in,
    input  logic        jr_in,
    input  logic        jal_in,
    input  logic        zero_in,
    input  logic [31:0] rs_data_in,
    output logic        fault_out,
    output logic [31:0] instr_count_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [31:0] count;
    logic        req_q;
    logic        valid_q;
    logic        fault_q;
    logic [31:0] next_pc;
    logic [31:0] branch_offset;
    logic        branch_taken;

    // The link value is taken from pc_plus4_out downstream; jal never steers the PC.
    logic unused_jal;
    assign unused_jal = jal_in;

    assign pc_plus4      = pc + 32'd4;
    assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign branch_taken  = (branch_in & zero_in) | (bne_in & ~zero_in);

    // jr is checked before jump because the control block raises both for jr.
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        next_pc = pc_plus4;
        if (jr_in)
            next_pc = rs_data_in;
        else if (jump_in)
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (branch_taken)
            next_pc = pc_plus4 + branch_offset;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            instr   <= 32'd0;
            count   <= 32'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    req_q <= 1'b1;
                end
                REQ: begin
                    if (imem_ack_in) begin
                        instr   <= imem_data_in;
                        state   <= VALID;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                VALID: begin
                    if (exec_done_in) begin
                        pc      <= next_pc;
                        count   <= count + 32'd1;
                        valid_q <= 1'b0;
                        // A misaligned target parks the stage until reset.
                        if (next_pc[1:0] != 2'b00) begin
                            state   <= FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state <= REQ;
                            req_q <= 1'b1;
                        end
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state   <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_out    = req_q;
    assign imem_addr_out   = pc;
    assign instr_out       = instr;
    assign op_out          = instr[31:26];
    assign func_out        = instr[5:0];
    assign instr_valid_out = valid_q;
    assign pc_out          = pc;
    assign pc_plus4_out    = pc_plus4;
    assign fault_out       = fault_q;
    assign instr_count_out = count;

endmodule

// File: tb/tb_mips_fetch.sv
// Self-checking bench for mips_fetch: a table of fetch/resolve vectors, a PC
// scoreboard queue, and hand sequences for fault, wraparound and reset corners.
module tb_mips_fetch;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] imem_data_in;
    logic [31:0] instr_out;
    logic [5:0]  op_out;
    logic [5:0]  func_out;
    logic        instr_valid_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic        exec_done_in;
    logic        branch_in;
    logic        bne_in;
    logic        jump_in;
    logic        jr_in;
    logic        jal_in;
    logic        zero_in;
    logic [31:0] rs_data_in;
    logic        fault_out;
    logic [31:0] instr_count_out;

    mips_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_out    (imem_req_out),
        .imem_addr_out   (imem_addr_out),
        .imem_ack_in     (imem_ack_in),
        .imem_data_in    (imem_data_in),
        .instr_out       (instr_out),
        .op_out          (op_out),
        .func_out        (func_out),
        .instr_valid_out (instr_valid_out),
        .pc_out          (pc_out),
        .pc_plus4_out    (pc_plus4_out),
        .exec_done_in    (exec_done_in),
        .branch_in       (branch_in),
        .bne_in          (bne_in),
        .jump_in         (jump_in),
        .jr_in           (jr_in),
        .jal_in          (jal_in),
        .zero_in         (zero_in),
        .rs_data_in      (rs_data_in),
        .fault_out       (fault_out),
        .instr_count_out (instr_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          ack_dly;
        int          exec_wait;
        logic        br;
        logic        bne;
        logic        jmp;
        logic        jr;
        logic        jal;
        logic        zero;
        logic [31:0] rs;
        logic [31:0] exp_pc;
        logic        exp_fault;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_count;
    logic [31:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input int ack_dly, input int exec_wait,
                                input logic br, input logic bne, input logic jmp,
                                input logic jr, input logic jal, input logic zero,
                                input logic [31:0] rs, input logic [31:0] exp_pc,
                                input logic exp_fault);
        vec_t v;
        v.pc = pc;       v.instr = instr;   v.ack_dly = ack_dly; v.exec_wait = exec_wait;
        v.br = br;       v.bne = bne;       v.jmp = jmp;         v.jr = jr;
        v.jal = jal;     v.zero = zero;     v.rs = rs;
        v.exp_pc = exp_pc; v.exp_fault = exp_fault;
        return v;
    endfunction

    task automatic scramble_res();
        {branch_in, bne_in, jump_in, jr_in, jal_in, zero_in} = 6'($urandom);
        rs_data_in = $urandom;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        imem_ack_in  = 1'b0;
        exec_done_in = 1'b0;
        #1;
        check("rst_pc", pc_out, RESET_PC);
        check("rst_pc4", pc_plus4_out, RESET_PC + 32'd4);
        check("rst_instr", instr_out, 32'd0);
        check("rst_op", 32'(op_out), 32'd0);
        check("rst_func", 32'(func_out), 32'd0);
        check("rst_valid", 32'(instr_valid_out), 32'd0);
        check("rst_req", 32'(imem_req_out), 32'd0);
        check("rst_fault", 32'(fault_out), 32'd0);
        check("rst_count", instr_count_out, 32'd0);
        exp_count = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        check("idle_req", 32'(imem_req_out), 32'd0);
        @(negedge clk);
        check("req_rise", 32'(imem_req_out), 32'd1);
        check("req_addr", imem_addr_out, RESET_PC);
    endtask

    // One fetch/execute round trip; the expected next PC goes through the scoreboard.
    task automatic run_vec(input vec_t v);
        logic [31:0] exp;
        int          waited;
        waited = 0;
        while (!imem_req_out && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("req_wait", 32'(imem_req_out), 32'd1);
        check("fetch_addr", imem_addr_out, v.pc);
        for (int d = 0; d < v.ack_dly; d++) begin
            @(negedge clk);
            check("req_hold", 32'(imem_req_out), 32'd1);
            check("addr_hold", imem_addr_out, v.pc);
            check("valid_low", 32'(instr_valid_out), 32'd0);
        end
        imem_ack_in  = 1'b1;
        imem_data_in = v.instr;
        @(negedge clk);
        imem_ack_in  = 1'b0;
        imem_data_in = $urandom;
        check("valid_rise", 32'(instr_valid_out), 32'd1);
        check("req_drop", 32'(imem_req_out), 32'd0);
        check("instr", instr_out, v.instr);
        check("op", 32'(op_out), 32'(v.instr[31:26]));
        check("func", 32'(func_out), 32'(v.instr[5:0]));
        check("pc_plus4", pc_plus4_out, v.pc + 32'd4);
        // Garbage on ack and resolution inputs while exec_done is low must not disturb anything.
        for (int w = 0; w < v.exec_wait; w++) begin
            scramble_res();
            imem_ack_in  = 1'b1;
            imem_data_in = ~v.instr;
            @(negedge clk);
            check("valid_hold", 32'(instr_valid_out), 32'd1);
            check("instr_hold", instr_out, v.instr);
            check("pc_hold", pc_out, v.pc);
        end
        imem_ack_in  = 1'b0;
        branch_in    = v.br;
        bne_in       = v.bne;
        jump_in      = v.jmp;
        jr_in        = v.jr;
        jal_in       = v.jal;
        zero_in      = v.zero;
        rs_data_in   = v.rs;
        exec_done_in = 1'b1;
        sb_q.push_back(v.exp_pc);
        exp_count = exp_count + 32'd1;
        @(negedge clk);
        exec_done_in = 1'b0;
        scramble_res();
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            exp = sb_q.pop_front();
            check("next_pc", pc_out, exp);
            check("next_addr", imem_addr_out, exp);
        end
        check("fault", 32'(fault_out), 32'(v.exp_fault));
        check("req_after", 32'(imem_req_out), 32'(!v.exp_fault));
        check("valid_after", 32'(instr_valid_out), 32'd0);
        check("count", instr_count_out, exp_count);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        reset        = 1'b1;
        imem_ack_in  = 1'b0;
        imem_data_in = 32'd0;
        exec_done_in = 1'b0;
        branch_in    = 1'b0;
        bne_in       = 1'b0;
        jump_in      = 1'b0;
        jr_in        = 1'b0;
        jal_in       = 1'b0;
        zero_in      = 1'b0;
        rs_data_in   = 32'd0;
        exp_count    = 32'd0;

        //             pc            instr         ack ex  br bne j  jr jal z  rs            exp_pc        flt
        vecs[0]  = mk(32'h0040_0000, 32'h0000_0000, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0040_0004, 0);
        vecs[1]  = mk(32'h0040_0004, 32'h0000_0000, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0040_0008, 0);
        vecs[2]  = mk(32'h0040_0008, 32'h0000_0000, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0040_000C, 0);
        vecs[3]  = mk(32'h0040_000C, 32'h0000_0000, 4, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0040_0010, 0);
        vecs[4]  = mk(32'h0040_0010, 32'h1000_FFFF, 0, 0, 1, 0, 0, 0, 0, 1, 32'h0,        32'h0040_0010, 0);
        vecs[5]  = mk(32'h0040_0010, 32'h1400_FFFF, 1, 2, 0, 1, 0, 0, 0, 1, 32'h0,        32'h0040_0014, 0);
        vecs[6]  = mk(32'h0040_0014, 32'h1400_0003, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0040_0024, 0);
        vecs[7]  = mk(32'h0040_0024, 32'h1000_0010, 2, 1, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0040_0028, 0);
        vecs[8]  = mk(32'h0040_0028, 32'h03E0_0008, 0, 0, 0, 0, 1, 1, 0, 0, 32'h0040_0000, 32'h0040_0000, 0);
        vecs[9]  = mk(32'h0040_0000, 32'h0810_0040, 0, 1, 0, 0, 1, 0, 0, 0, 32'h0,        32'h0040_0100, 0);
        vecs[10] = mk(32'h0040_0100, 32'h03E0_0008, 3, 0, 1, 0, 1, 1, 0, 1, 32'h0040_0000, 32'h0040_0000, 0);
        vecs[11] = mk(32'h0040_0000, 32'h0C10_0040, 0, 2, 0, 0, 1, 0, 1, 0, 32'h0,        32'h0040_0100, 0);
        vecs[12] = mk(32'h0040_0100, 32'h03E0_0008, 0, 0, 0, 0, 1, 1, 0, 0, 32'h0040_0200, 32'h0040_0200, 0);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i]);
            if (i == 2)
                check("count_three", instr_count_out, 32'd3);
        end

        // Positive branch offset, jr-over-jump-and-branch priority, jump-over-branch priority.
        run_vec(mk(32'h0040_0200, 32'h1000_7FFF, 0, 0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h0042_0200, 0));
        run_vec(mk(32'h0042_0200, 32'h03E0_0008, 0, 0, 1, 0, 1, 1, 0, 1, 32'h0040_0300, 32'h0040_0300, 0));
        run_vec(mk(32'h0040_0300, 32'h0810_0000, 0, 0, 1, 0, 1, 0, 0, 1, 32'h0, 32'h0040_0000, 0));

        // Misaligned jr target: sticky fault, no further requests, inputs ignored.
        run_vec(mk(32'h0040_0000, 32'h03E0_0008, 0, 0, 0, 0, 1, 1, 0, 0, 32'h0040_0202, 32'h0040_0202, 1));
        for (int c = 0; c < 5; c++) begin
            imem_ack_in  = 1'b1;
            exec_done_in = 1'b1;
            scramble_res();
            @(negedge clk);
            check("fault_sticky", 32'(fault_out), 32'd1);
            check("fault_noreq", 32'(imem_req_out), 32'd0);
            check("fault_novalid", 32'(instr_valid_out), 32'd0);
            check("fault_pc", pc_out, 32'h0040_0202);
            check("fault_count", instr_count_out, exp_count);
        end
        imem_ack_in  = 1'b0;
        exec_done_in = 1'b0;

        // Reset recovers; then PC wraparound through 0xFFFF_FFFC.
        do_reset();
        run_vec(mk(32'h0040_0000, 32'h03E0_0008, 0, 0, 0, 0, 1, 1, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0));
        run_vec(mk(32'hFFFF_FFFC, 32'h0000_0000, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0000, 0));

        // Reset asserted in REQ together with an ack; the late ack after release is ignored.
        check("pre_rst_req", 32'(imem_req_out), 32'd1);
        imem_ack_in  = 1'b1;
        imem_data_in = 32'hDEAD_BEEF;
        reset        = 1'b1;
        #1;
        check("midrst_instr", instr_out, 32'd0);
        check("midrst_count", instr_count_out, 32'd0);
        check("midrst_req", 32'(imem_req_out), 32'd0);
        check("midrst_pc", pc_out, RESET_PC);
        @(negedge clk);
        check("midrst_hold", instr_out, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("late_ack_instr", instr_out, 32'd0);
        check("late_ack_valid", 32'(instr_valid_out), 32'd0);
        check("late_ack_req", 32'(imem_req_out), 32'd1);
        check("late_ack_count", instr_count_out, 32'd0);
        imem_ack_in = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_fetch.md
# mips_fetch

Instruction-fetch stage for the single-issue MIPS datapath. It sits directly upstream of `MIPS_CONTROL` and drives its `op_in` and `func_in` from the fetched instruction word. It holds the PC, runs a req/ack handshake with instruction memory, and presents one instruction at a time until the datapath reports it executed. It then computes the next PC from the branch/jump decode signals and the ALU zero flag.

## Interface
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; one clock; clears all state.
- imem_req_out  out  1  instruction read request.
- imem_addr_out  out  32  read address; always equals pc_out.
- imem_ack_in  in  1  memory returns data this cycle.
- imem_data_in  in  32  instruction word, valid when imem_ack_in=1.
- instr_out  out  32  captured instruction.
- op_out  out  6  instr_out[31:26], to the control op_in.
- func_out  out  6  instr_out[5:0], to the control func_in.
- instr_valid_out  out  1  instr_out is current and executing.
- pc_out  out  32  PC of the current instruction.
- pc_plus4_out  out  32  pc_out+4; this is the jal link value.
- exec_done_in  in  1  datapath finished the current instruction; the resolution inputs below are valid this cycle.
- branch_in, bne_in, jump_in, jr_in, jal_in  in  1 each  from the control block.
- zero_in  in  1  ALU zero flag.
- rs_data_in  in  32  R[rs], the jr target.
- fault_out  out  1  sticky misaligned-target fault.
- instr_count_out  out  32  retired-instruction counter.

## Operation
- FSM states are IDLE, REQ, VALID and FAULT.
- **IDLE:** Entered on reset. Moves unconditionally to REQ on the next clock.
- **REQ:**
  - imem_req_out=1, and imem_addr_out stays stable until ack.
  - On imem_ack_in=1, capture imem_data_in into instr_out and go to VALID.
- **VALID:**
  - instr_valid_out=1, and instr_out stays stable.
  - On exec_done_in=1:
    - Load the PC with next_pc.
    - Increment instr_count_out.
    - Go to REQ, or to FAULT if next_pc[1:0]≠0.
  - Without exec_done_in, stay in VALID indefinitely.
- **FAULT:**
  - imem_req_out=0, instr_valid_out=0, fault_out=1.
  - The PC holds the faulting target.
  - Exit only through reset.
- **next_pc**, first match wins:
  1. jr_in=1: rs_data_in. This takes priority even though jump_in is also 1 for jr.
  2. jump_in=1 (j, jal): {pc_plus4[31:28], instr[25:0], 2'b00}.
  3. (branch_in & zero_in) | (bne_in & ~zero_in): pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  4. Otherwise: pc_plus4.
- Arithmetic is 32-bit modulo 2^32; the PC wraps from 32'hFFFF_FFFC to 0. The counter wraps from 32'hFFFF_FFFF to 0.
- Inputs are ignored outside their state:
  - imem_ack_in is ignored outside REQ.
  - exec_done_in is ignored outside VALID.
  - X values on the resolution inputs are ignored while exec_done_in=0, because the control block drives X on unknown opcodes.
- jal_in does not affect next_pc; the link register write uses pc_plus4_out.

## Timing
- Reset values (asynchronous):
  - state=IDLE, pc_out=RESET_PC, pc_plus4_out=RESET_PC+4.
  - instr_out=0, so op_out=0 and func_out=0, which decodes as the nop case.
  - instr_valid_out=0, imem_req_out=0, fault_out=0, instr_count_out=0.
- imem_req_out first rises 1 cycle after reset deassertion.
- Ack at edge N gives instr_valid_out=1 from N.
- exec_done_in at edge M produces, from M:
  - the new pc_out,
  - imem_req_out=1,
  - instr_valid_out=0.
- Minimum throughput is 2 cycles per instruction: ack in the first REQ cycle and exec_done in the first VALID cycle.
- All outputs are registered or derived combinationally from registers only. No input-to-output combinational path exists.
- Reset asserted mid-handshake clears the state immediately. A late ack after reset is ignored because the FSM is in IDLE.

## Test plan
- Reset, then zero-latency memory with sequential nops and exec_done one cycle after valid -> addresses 0x00400000, 0x00400004, 0x00400008, with instr_count_out reaching 3.
- Ack delayed 4 cycles in REQ -> imem_addr_out and imem_req_out stable throughout, and instr_valid_out rises at the ack edge.
- Branch at 0x00400010 with imm=0xFFFF:
  - beq with zero=1 -> next address 0x00400010.
  - bne with zero=1 -> next address 0x00400014.
- j with target field 0x0100040 at pc 0x00400000 -> next pc 0x00400100. jal gives the same target, with pc_plus4_out=0x00400004 during VALID.
- jr with jump_in=1 and rs_data_in:
  - 0x00400200 -> next pc 0x00400200.
  - 0x00400202 -> FAULT, fault_out=1, no further requests, and reset recovers to RESET_PC.
- Reset asserted during REQ with an ack arriving the same cycle -> instr_out=0, count=0, and a new request one cycle after release.
